// File: rtl/image_write_if.sv
`default_nettype none
// ============================================================================
// Module   : image_write_if
// Brief    : Config bus, pixel-group stream and memory-write bundle for image_write.
// Revision : 1.0  initial release
// ============================================================================
interface image_write_if #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16
);
  logic [CFG_DWIDTH-1:0]         cfg_data;
  logic [CFG_AWIDTH-1:0]         cfg_addr;
  logic                          cfg_valid;
  logic                          next;
  logic [GROUP_NB*IMG_WIDTH-1:0] str_bus;
  logic                          str_last;
  logic                          str_val;
  logic                          str_rdy;
  logic                          wr_val;
  logic [MEM_AWIDTH-1:0]         wr_addr;
  logic [GROUP_NB*IMG_WIDTH-1:0] wr_data;
  logic                          done;
  logic                          error;

  modport master (
    output cfg_data, cfg_addr, cfg_valid, next, str_bus, str_last, str_val,
    input  str_rdy, wr_val, wr_addr, wr_data, done, error
  );

  modport slave (
    input  cfg_data, cfg_addr, cfg_valid, next, str_bus, str_last, str_val,
    output str_rdy, wr_val, wr_addr, wr_data, done, error
  );
endinterface
`default_nettype wire

// File: rtl/image_write.sv
`default_nettype none
// ============================================================================
// Module   : image_write
// Brief    : Writes a pixel-group stream into image memory using a configured
//            width/height/depth geometry with row and plane strides.
// Revision : 1.0  initial release
// ============================================================================
module image_write #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  image_write_if.slave bus_if
);
  localparam int BUS_W = GROUP_NB * IMG_WIDTH;

  localparam logic [CFG_AWIDTH-1:0] CFG_IW_IMG_W  = CFG_AWIDTH'(6);
  localparam logic [CFG_AWIDTH-1:0] CFG_IW_IMG_DH = CFG_AWIDTH'(7);
  localparam logic [CFG_AWIDTH-1:0] CFG_IW_BASE   = CFG_AWIDTH'(8);
  localparam logic [CFG_AWIDTH-1:0] CFG_IW_STRIDE = CFG_AWIDTH'(9);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [15:0]           img_w_q, img_h_q, img_d_q;
  logic [15:0]           row_stride_q, plane_stride_q;
  logic [MEM_AWIDTH-1:0] base_q;
  logic [15:0]           w_q, h_q, d_q;
  logic [MEM_AWIDTH-1:0] addr_q, row_base_q, plane_base_q;
  logic                  wr_val_q, done_q, error_q;
  logic [MEM_AWIDTH-1:0] wr_addr_q;
  logic [BUS_W-1:0]      wr_data_q;

  logic                  w_str_rdy, w_accept, w_final, w_start, w_cfg_we;
  logic [MEM_AWIDTH-1:0] w_row_next, w_plane_next;

  assign w_accept     = bus_if.str_val && w_str_rdy;
  assign w_start      = (state_q == ST_IDLE) && bus_if.next;
  assign w_cfg_we     = (state_q == ST_IDLE) && bus_if.cfg_valid;
  assign w_final      = (w_q == img_w_q) && (h_q == img_h_q) && (d_q == img_d_q);
  assign w_row_next   = row_base_q + MEM_AWIDTH'(row_stride_q);
  assign w_plane_next = plane_base_q + MEM_AWIDTH'(plane_stride_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus_if.next) state_d = ST_ACTIVE;
      ST_ACTIVE: if (w_accept && w_final) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Ready depends on state only, so the producer never sees a path from str_val.
  always_comb begin
    w_str_rdy = 1'b0;
    if (state_q == ST_ACTIVE) w_str_rdy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      img_w_q        <= '0;
      img_h_q        <= '0;
      img_d_q        <= '0;
      base_q         <= '0;
      row_stride_q   <= '0;
      plane_stride_q <= '0;
      w_q            <= '0;
      h_q            <= '0;
      d_q            <= '0;
      addr_q         <= '0;
      row_base_q     <= '0;
      plane_base_q   <= '0;
      wr_val_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      wr_val_q <= w_accept;
      done_q   <= w_accept && w_final;

      if (w_accept) begin
        wr_addr_q <= addr_q;
        wr_data_q <= bus_if.str_bus;
        if (bus_if.str_last != w_final) error_q <= 1'b1;
        if (w_q < img_w_q) begin
          w_q    <= w_q + 16'd1;
          addr_q <= addr_q + MEM_AWIDTH'(1);
        end else begin
          w_q <= '0;
          if (h_q < img_h_q) begin
            h_q        <= h_q + 16'd1;
            row_base_q <= w_row_next;
            addr_q     <= w_row_next;
          end else begin
            h_q          <= '0;
            d_q          <= d_q + 16'd1;
            plane_base_q <= w_plane_next;
            row_base_q   <= w_plane_next;
            addr_q       <= w_plane_next;
          end
        end
      end

      // Frame start samples base_q before any same-cycle cfg write lands.
      if (w_start) begin
        w_q          <= '0;
        h_q          <= '0;
        d_q          <= '0;
        addr_q       <= base_q;
        row_base_q   <= base_q;
        plane_base_q <= base_q;
        error_q      <= 1'b0;
      end

      if (w_cfg_we) begin
        case (bus_if.cfg_addr)
          CFG_IW_IMG_W:  img_w_q <= bus_if.cfg_data[15:0];
          CFG_IW_IMG_DH: begin
            img_d_q <= bus_if.cfg_data[31:16];
            img_h_q <= bus_if.cfg_data[15:0];
          end
          CFG_IW_BASE:   base_q <= bus_if.cfg_data[MEM_AWIDTH-1:0];
          CFG_IW_STRIDE: begin
            plane_stride_q <= bus_if.cfg_data[31:16];
            row_stride_q   <= bus_if.cfg_data[15:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign bus_if.str_rdy = w_str_rdy;
  assign bus_if.wr_val  = wr_val_q;
  assign bus_if.wr_addr = wr_addr_q;
  assign bus_if.wr_data = wr_data_q;
  assign bus_if.done    = done_q;
  assign bus_if.error   = error_q;
endmodule
`default_nettype wire

// File: tb/tb_image_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_write
// Brief    : Table-driven directed bench for image_write; one vector per clock.
// Revision : 1.0  initial release
// ============================================================================
module tb_image_write;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  image_write_if #(
    .CFG_DWIDTH(32), .CFG_AWIDTH(5), .GROUP_NB(4), .IMG_WIDTH(16), .MEM_AWIDTH(16)
  ) iw ();

  image_write #(
    .CFG_DWIDTH(32), .CFG_AWIDTH(5), .GROUP_NB(4), .IMG_WIDTH(16), .MEM_AWIDTH(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (iw)
  );

  // Inputs applied before an edge; expected outputs are those seen just after it.
  typedef struct {
    logic        r, nx, cv;
    logic [4:0]  ca;
    logic [31:0] cd;
    logic        v, l;
    logic [63:0] bus;
    logic        e_rdy, e_wv;
    logic [15:0] e_addr;
    logic [63:0] e_data;
    logic        e_done, e_err;
  } vec_t;

  vec_t        tv[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] h_addr = '0;
  logic [63:0] h_data = '0;
  int          a1[16] = '{100, 101, 102, 103, 108, 109, 110, 111,
                          132, 133, 134, 135, 140, 141, 142, 143};

  function automatic void add(input logic r, nx, cv, input logic [4:0] ca,
                              input logic [31:0] cd, input logic v, l,
                              input logic [63:0] bus, input logic e_rdy, e_wv,
                              input logic [15:0] e_addr, input logic [63:0] e_data,
                              input logic e_done, e_err);
    vec_t t;
    t.r = r; t.nx = nx; t.cv = cv; t.ca = ca; t.cd = cd;
    t.v = v; t.l = l; t.bus = bus;
    t.e_rdy = e_rdy; t.e_wv = e_wv; t.e_addr = e_addr; t.e_data = e_data;
    t.e_done = e_done; t.e_err = e_err;
    tv.push_back(t);
  endfunction

  function automatic void beat(input logic [15:0] a, input logic [63:0] d,
                               input logic last, e_rdy, e_done, e_err);
    add(0, 0, 0, 5'd0, 32'd0, 1, last, d, e_rdy, 1, a, d, e_done, e_err);
    h_addr = a;
    h_data = d;
  endfunction

  function automatic void idle(input logic v, e_rdy, e_err);
    add(0, 0, 0, 5'd0, 32'd0, v, 0, 64'hDEAD_BEEF_0000_0000, e_rdy, 0, h_addr, h_data, 0, e_err);
  endfunction

  function automatic void cfg(input logic [4:0] ca, input logic [31:0] cd,
                              input logic e_rdy, e_err);
    add(0, 0, 1, ca, cd, 0, 0, 64'd0, e_rdy, 0, h_addr, h_data, 0, e_err);
  endfunction

  function automatic void nxt();
    add(0, 1, 0, 5'd0, 32'd0, 0, 0, 64'd0, 1, 0, h_addr, h_data, 0, 0);
  endfunction

  function automatic void rst_vec();
    add(1, 0, 0, 5'd0, 32'd0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 16'd0, 64'd0, 0, 0);
    h_addr = '0;
    h_data = '0;
  endfunction

  task automatic run(input string tag);
    logic [83:0] act, exp;
    foreach (tv[i]) begin
      rst          = tv[i].r;
      iw.next      = tv[i].nx;
      iw.cfg_valid = tv[i].cv;
      iw.cfg_addr  = tv[i].ca;
      iw.cfg_data  = tv[i].cd;
      iw.str_val   = tv[i].v;
      iw.str_last  = tv[i].l;
      iw.str_bus   = tv[i].bus;
      @(posedge clk);
      #1;
      act = {iw.str_rdy, iw.wr_val, iw.wr_addr, iw.wr_data, iw.done, iw.error};
      exp = {tv[i].e_rdy, tv[i].e_wv, tv[i].e_addr, tv[i].e_data, tv[i].e_done, tv[i].e_err};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s[%0d]: got rdy=%b wv=%b addr=%h data=%h done=%b err=%b, expected rdy=%b wv=%b addr=%h data=%h done=%b err=%b",
                 tag, i, iw.str_rdy, iw.wr_val, iw.wr_addr, iw.wr_data, iw.done, iw.error,
                 tv[i].e_rdy, tv[i].e_wv, tv[i].e_addr, tv[i].e_data, tv[i].e_done, tv[i].e_err);
      end
    end
    tv.delete();
    rst = 1'b0; iw.next = 1'b0; iw.cfg_valid = 1'b0; iw.str_val = 1'b0; iw.str_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    iw.next = 1'b0; iw.cfg_valid = 1'b0; iw.cfg_addr = '0; iw.cfg_data = '0;
    iw.str_val = 1'b0; iw.str_last = 1'b0; iw.str_bus = '0;

    rst_vec(); rst_vec();
    run("reset");

    // 4x2x2 frame, base 100, row stride 8, plane stride 32, back-to-back
    cfg(5'd6, 32'd3, 0, 0);
    cfg(5'd7, 32'h0001_0001, 0, 0);
    cfg(5'd8, 32'd100, 0, 0);
    cfg(5'd9, 32'h0020_0008, 0, 0);
    cfg(5'd3, 32'hFFFF_FFFF, 0, 0);
    nxt();
    for (int k = 0; k < 16; k++) beat(16'(a1[k]), 64'(k), k == 15, k != 15, k == 15, 0);
    idle(0, 0, 0);
    idle(1, 0, 0);
    run("b2b");

    // Same frame with toggled valid then 3-cycle gaps
    nxt();
    for (int k = 0; k < 16; k++) begin
      beat(16'(a1[k]), 64'(k), k == 15, k != 15, k == 15, 0);
      if (k < 8) idle(0, 1, 0);
      else if (k < 15) begin
        idle(0, 1, 0); idle(0, 1, 0); idle(0, 1, 0);
      end
    end
    idle(0, 0, 0);
    run("gaps");

    // Early str_last on beat 5, missing on beat 16: sticky error until next
    nxt();
    for (int k = 0; k < 16; k++)
      beat(16'(a1[k]), 64'h5500_0000_0000_0000 | 64'(k), k == 4, k != 15, k == 15, k >= 4);
    idle(0, 0, 1);
    nxt();
    run("lasterr");

    // Mid-frame next / BASE write / width write are all ignored
    for (int k = 0; k < 16; k++) begin
      beat(16'(a1[k]), 64'hC0DE_0000_0000_0000 | 64'(k), k == 15, k != 15, k == 15, 0);
      if (k == 5) add(0, 1, 1, 5'd8, 32'd500, 0, 0, 64'd0, 1, 0, h_addr, h_data, 0, 0);
      if (k == 9) add(0, 0, 1, 5'd6, 32'd0, 0, 0, 64'd0, 1, 0, h_addr, h_data, 0, 0);
    end
    idle(0, 0, 0);
    cfg(5'd6, 32'd3, 0, 0);
    cfg(5'd7, 32'd0, 0, 0);
    nxt();
    for (int k = 0; k < 4; k++) beat(16'(100 + k), 64'(k + 40), k == 3, k != 3, k == 3, 0);
    // cfg write with next: frame still starts from the old base
    add(0, 1, 1, 5'd8, 32'h0000_FFFE, 0, 0, 64'd0, 1, 0, h_addr, h_data, 0, 0);
    for (int k = 0; k < 4; k++) beat(16'(100 + k), 64'(k + 50), k == 3, k != 3, k == 3, 0);
    run("ignore");

    // Address wrap from base 0xFFFE
    nxt();
    beat(16'hFFFE, 64'hA0, 0, 1, 0, 0);
    beat(16'hFFFF, 64'hA1, 0, 1, 0, 0);
    beat(16'h0000, 64'hA2, 0, 1, 0, 0);
    beat(16'h0001, 64'hA3, 1, 0, 1, 0);
    idle(0, 0, 0);
    run("wrap");

    // Reset after beat 3 of a 16-beat frame
    cfg(5'd7, 32'h0001_0001, 0, 0);
    cfg(5'd8, 32'd100, 0, 0);
    nxt();
    for (int k = 0; k < 3; k++) beat(16'(a1[k]), 64'(k + 70), 0, 1, 0, 0);
    rst_vec();
    idle(1, 0, 0);
    // Cleared cfg gives a 1x1x1 frame at address 0
    nxt();
    beat(16'h0000, 64'h5A5A, 1, 0, 1, 0);
    cfg(5'd6, 32'd1, 0, 0);
    cfg(5'd7, 32'h0000_0001, 0, 0);
    cfg(5'd8, 32'd20, 0, 0);
    cfg(5'd9, 32'h0000_0004, 0, 0);
    nxt();
    beat(16'd20, 64'h90, 0, 1, 0, 0);
    beat(16'd21, 64'h91, 0, 1, 0, 0);
    beat(16'd24, 64'h92, 0, 1, 0, 0);
    beat(16'd25, 64'h93, 1, 0, 1, 0);
    idle(0, 0, 0);
    run("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/image_write.md
Name: image_write

Overview:
- Write-side counterpart of the image-buffer reader.
- Accepts the processed pixel-group stream (one GROUP_NB x IMG_WIDTH word per beat) from the conv/maxpool pipeline and writes it into image buffer memory.
- Write addresses come from a configured frame geometry (width, height, depth, base, row/plane strides).
- Configured over the shared cfg bus; each frame is started by a `next` pulse.

Parameters:
- CFG_DWIDTH, 32: config data width.
- CFG_AWIDTH, 5: config address width.
- GROUP_NB, 4: pixels per stream/memory word.
- IMG_WIDTH, 16: bits per pixel.
- MEM_AWIDTH, 16: image memory address width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- cfg_data  in  CFG_DWIDTH  config write data.
- cfg_addr  in  CFG_AWIDTH  config register address.
- cfg_valid  in  1  config write strobe.
- next  in  1  start-frame pulse.
- str_bus  in  GROUP_NB*IMG_WIDTH  incoming pixel group.
- str_last  in  1  producer marks final beat of frame.
- str_val  in  1  incoming beat valid.
- str_rdy  out  1  block can accept beat.
- wr_val  out  1  memory write enable.
- wr_addr  out  MEM_AWIDTH  memory write address.
- wr_data  out  GROUP_NB*IMG_WIDTH  memory write data.
- done  out  1  one-cycle pulse, frame complete.
- error  out  1  sticky frame/last mismatch flag.

Behaviour:

Config registers (localparams):
- CFG_IW_IMG_W = 6: width-1 in [15:0].
- CFG_IW_IMG_DH = 7: {depth-1[31:16], height-1[15:0]}.
- CFG_IW_BASE = 8: base address in [MEM_AWIDTH-1:0].
- CFG_IW_STRIDE = 9: {plane_stride[31:16], row_stride[15:0]}.
- Other addresses are ignored.
- cfg writes apply only in IDLE; writes while ACTIVE are ignored.

Reset:
- state=IDLE; all cfg registers=0.
- str_rdy=0, wr_val=0, wr_addr=0, wr_data=0, done=0, error=0.
- Reset mid-frame aborts the frame: wr_val=0 from the next cycle, no done pulse.

State machine:
- IDLE --next--> ACTIVE.
  - On next: w=h=d=0, addr=row_base=plane_base=BASE, error cleared.
  - next while ACTIVE is ignored.
- ACTIVE --final beat accepted--> IDLE.
- str_rdy = (state==ACTIVE), driven from the state register only; no combinational path from str_val.

Beat acceptance:
- A beat is accepted when str_val && str_rdy. Full throughput: 1 beat/cycle, back-to-back.
- Write latency 1 cycle: on the cycle after acceptance, wr_val=1, wr_addr=addr at acceptance, wr_data=str_bus at acceptance. Otherwise wr_val=0; wr_addr/wr_data hold.

Counters on each accepted beat (accumulating adders, no multipliers):
- If w<W-1: w++, addr++.
- Else w=0:
  - If h<H-1: h++, row_base+=row_stride, addr=row_base+row_stride.
  - Else h=0, d++, plane_base+=plane_stride, row_base=addr=plane_base+plane_stride.
- Final beat: w==W-1 && h==H-1 && d==D-1.
- All address arithmetic is modulo 2^MEM_AWIDTH (wrap silently).

Completion and error:
- done=1 in the same cycle as the final beat's wr_val.
- error set (sticky until the next accepted next) if:
  - str_last=1 on a non-final beat, or
  - str_last=0 on the final beat.
- Frame counting continues regardless of str_last; str_last never terminates a frame early.

Simultaneous events:
- cfg_valid with next in IDLE: the cfg write takes effect, and the frame start uses the old register value for that cycle's loaded fields.
- rst has priority over everything.

Test Plan:
- Cfg W-1=3, H-1=1, D-1=1, BASE=100, row_stride=8, plane_stride=32; next; 16 back-to-back beats data=k, str_last on beat 16 -> wr_addr 100-103, 108-111, 132-135, 140-143 with wr_data 0..15; done pulses with the 16th write; error=0; str_rdy=0 afterwards.
- Same config with str_val toggled 1/0 and 3-cycle gaps -> identical address/data sequence; wr_val only on the cycle after each accepted beat.
- str_last asserted on beat 5, not on beat 16 -> error=1 from beat 5; all 16 writes still issued; done still pulses; next clears error.
- BASE=0xFFFE, W-1=3, H-1=0, D-1=0 -> wr_addr FFFE, FFFF, 0000, 0001; done on the 4th write.
- next pulsed mid-frame and cfg write to CFG_IW_BASE mid-frame -> ignored; the frame completes with original addresses; the new BASE is accepted in IDLE afterwards.
- rst after beat 3 of 16 -> wr_val=0 and str_rdy=0 next cycle, no done, cfg reads back as 0; a fresh cfg + next runs a clean frame.
